// File: rtl/cic_comp_pkg.sv
// Shared types, default coefficients and sizing helpers for the CIC compensation FIR.
package cic_comp_pkg;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    localparam int DEF_INPUT_WIDTH = 12;
    localparam int DEF_COEF_WIDTH  = 16;
    localparam int DEF_N_TAPS      = 15;

    // Symmetric droop compensator, Q1.15. The taps sum to 32768, so DC gain is exactly one.
    localparam logic [DEF_N_TAPS-1:0][DEF_COEF_WIDTH-1:0] COMP_COEFS = {
        -16'sd64,  16'sd128, -16'sd256, 16'sd512, -16'sd1024, 16'sd2048, 16'sd6000,
        16'sd18080,
        16'sd6000, 16'sd2048, -16'sd1024, 16'sd512, -16'sd256, 16'sd128, -16'sd64
    };

    // Output clamp limits for the default sample width.
    localparam int SAT_MAX = (2 ** (DEF_INPUT_WIDTH - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (DEF_INPUT_WIDTH - 1));

    // The accumulator is wide enough that a full sum of N_TAPS products cannot wrap.
    function automatic int acc_width(input int iw, input int cw, input int nt);
        return iw + cw + $clog2(nt);
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Ring buffer of N samples. The read port takes an age offset: 0 is the newest sample.
module fir_delay_line #(
    parameter int W  = 12,
    parameter int N  = 15,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          we,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] rd_off,
    output logic [W-1:0]  rdata
);

    logic [N-1:0][W-1:0] mem;
    logic [AW-1:0]       wptr;
    logic [AW:0]         idx;

    // Write at the pointer, then advance it with wrap at N-1.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mem  <= '0;
            wptr <= '0;
        end else if (we) begin
            mem[wptr] <= wdata;
            wptr      <= (wptr == AW'(N - 1)) ? '0 : wptr + 1'b1;
        end
    end

    // Newest entry sits at wptr-1; the biased sum stays below 2N so a single subtract wraps it.
    always_comb begin
        idx = {1'b0, wptr} + (AW + 1)'(N - 1) - {1'b0, rd_off};
        if (idx >= (AW + 1)'(N)) idx = idx - (AW + 1)'(N);
        rdata = mem[idx[AW-1:0]];
    end

endmodule

// File: rtl/cic_comp_fir.sv
// Single-MAC CIC compensation FIR with extra decimation and saturated output.
module cic_comp_fir
    import cic_comp_pkg::*;
#(
    parameter int INPUT_WIDTH = 12,
    parameter int COEF_WIDTH  = 16,
    parameter int N_TAPS      = 15,
    parameter int OUT_DECIM   = 2,
    parameter logic [N_TAPS-1:0][COEF_WIDTH-1:0] COEFS = COMP_COEFS
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic signed [INPUT_WIDTH-1:0] d_in,
    input  logic                          d_clk,
    output logic signed [INPUT_WIDTH-1:0] d_out,
    output logic                          d_valid,
    output logic                          overrun
);

    localparam int ACC_W = acc_width(INPUT_WIDTH, COEF_WIDTH, N_TAPS);
    localparam int PRD_W = INPUT_WIDTH + COEF_WIDTH;
    localparam int TW    = $clog2(N_TAPS);
    localparam int PHW   = (OUT_DECIM > 1) ? $clog2(OUT_DECIM) : 1;
    localparam logic signed [ACC_W-1:0]       RND    = ACC_W'(1 << (COEF_WIDTH - 2));
    localparam logic signed [INPUT_WIDTH-1:0] SAT_HI = {1'b0, {(INPUT_WIDTH-1){1'b1}}};
    localparam logic signed [INPUT_WIDTH-1:0] SAT_LO = {1'b1, {(INPUT_WIDTH-1){1'b0}}};

    state_t                          state, state_nx;
    logic                            d_clk_q, strb, accept, due;
    logic [PHW-1:0]                  phase;
    logic [TW-1:0]                   tap;
    logic [INPUT_WIDTH-1:0]          line_q;
    logic signed [PRD_W-1:0]         prod;
    logic signed [ACC_W-1:0]         acc, rnd, shf;
    logic signed [INPUT_WIDTH-1:0]   sat;

    assign strb   = d_clk & ~d_clk_q;
    assign accept = strb && (state == IDLE);
    assign due    = (phase == PHW'(OUT_DECIM - 1));

    fir_delay_line #(.W(INPUT_WIDTH), .N(N_TAPS), .AW(TW)) u_line (
        .clk    (clk),
        .arst_n (arst_n),
        .we     (accept),
        .wdata  (d_in),
        .rd_off (tap),
        .rdata  (line_q)
    );

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_nx;
    end

    // Next state: a sample only kicks off a MAC pass when it completes a decimation group.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && due) state_nx = MAC;
            MAC:     if (tap == TW'(N_TAPS - 1)) state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // One product per cycle; tap k pairs COEFS[k] with the k-th newest sample.
    always_comb begin
        prod = $signed(line_q) * $signed(COEFS[tap]);
        rnd  = acc + RND;
        shf  = rnd >>> (COEF_WIDTH - 1);
        if (shf > ACC_W'(SAT_HI))      sat = SAT_HI;
        else if (shf < ACC_W'(SAT_LO)) sat = SAT_LO;
        else                           sat = shf[INPUT_WIDTH-1:0];
    end

    // Strobe edge detect, decimation phase and sticky overrun.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            d_clk_q <= 1'b0;
            phase   <= '0;
            overrun <= 1'b0;
        end else begin
            d_clk_q <= d_clk;
            if (accept)                   phase   <= due ? '0 : phase + 1'b1;
            if (strb && (state != IDLE))  overrun <= 1'b1;
        end
    end

    // Accumulator and tap counter; cleared as the MAC pass starts.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            acc <= '0;
            tap <= '0;
        end else if (accept && due) begin
            acc <= '0;
            tap <= '0;
        end else if (state == MAC) begin
            acc <= acc + ACC_W'(prod);
            if (tap != TW'(N_TAPS - 1)) tap <= tap + 1'b1;
        end
    end

    // Output register: d_out moves only together with the d_valid pulse.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            d_out   <= '0;
            d_valid <= 1'b0;
        end else begin
            d_valid <= (state == OUT);
            if (state == OUT) d_out <= sat;
        end
    end

endmodule
